// File: rtl/wb_arbiter.sv
// Writeback arbiter: loads win the single register-file write port, colliding EX results wait in an in-order FIFO.
// Define WB_BYPASS_EN to add the decode-stage bypass lookup ports (byp_rs*/byp_hit*/byp_data*).
module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int RF_IDX_WIDTH = 5,
    parameter int rv32_XLEN    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          EXen_wb,
    input  logic [RF_IDX_WIDTH-1:0]       EXrd_wb,
    input  logic [rv32_XLEN-1:0]          EXdata_wb,
    input  logic                          Men_wb,
    input  logic [RF_IDX_WIDTH-1:0]       Mrd_wb,
    input  logic [rv32_XLEN-1:0]          Mdata_wb,
`ifdef WB_BYPASS_EN
    input  logic [RF_IDX_WIDTH-1:0]       byp_rs1,
    input  logic [RF_IDX_WIDTH-1:0]       byp_rs2,
    output logic                          byp_hit1,
    output logic                          byp_hit2,
    output logic [rv32_XLEN-1:0]          byp_data1,
    output logic [rv32_XLEN-1:0]          byp_data2,
`endif
    output logic                          rf_we,
    output logic [RF_IDX_WIDTH-1:0]       rf_waddr,
    output logic [rv32_XLEN-1:0]          rf_wdata,
    output logic                          wb_stall,
    output logic                          wb_overflow,
    output logic [$clog2(DEPTH+1)-1:0]    wb_cnt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0]        valid;
    logic [RF_IDX_WIDTH-1:0] ent_rd   [DEPTH];
    logic [rv32_XLEN-1:0]    ent_data [DEPTH];
    logic [PW-1:0]           head;
    logic [PW-1:0]           tail;
    logic [CW-1:0]           cnt;

    logic                    ex_ok;
    logic                    m_ok;
    logic                    do_write;
    logic                    do_push;
    logic                    do_pop;
    logic                    overflow_set;
    logic [RF_IDX_WIDTH-1:0] w_addr;
    logic [rv32_XLEN-1:0]    w_data;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Requests to x0 are treated as if they never arrived.
    assign ex_ok    = EXen_wb && (EXrd_wb != '0);
    assign m_ok     = Men_wb && (Mrd_wb != '0);
    assign wb_cnt   = cnt;
    assign wb_stall = (cnt >= CW'(DEPTH - 1));

    always_comb begin
        do_write     = 1'b0;
        do_push      = 1'b0;
        do_pop       = 1'b0;
        overflow_set = 1'b0;
        w_addr       = Mrd_wb;
        w_data       = Mdata_wb;
        if (m_ok) begin
            do_write = 1'b1;
            if (ex_ok) begin
                if (cnt == CW'(DEPTH)) overflow_set = 1'b1;
                else                   do_push      = 1'b1;
            end
        end else if (cnt != '0) begin
            do_pop   = 1'b1;
            do_write = valid[head];
            w_addr   = ent_rd[head];
            w_data   = ent_data[head];
            do_push  = ex_ok;
        end else if (ex_ok) begin
            do_write = 1'b1;
            w_addr   = EXrd_wb;
            w_data   = EXdata_wb;
        end
    end

    // Supersede clears run before the pop/push updates so a same-cycle push keeps its valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            cnt         <= '0;
            valid       <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            wb_overflow <= 1'b0;
        end else begin
            rf_we <= do_write;
            if (do_write) begin
                rf_waddr <= w_addr;
                rf_wdata <= w_data;
            end
            if (m_ok) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_rd[i] == Mrd_wb) valid[i] <= 1'b0;
                end
            end
            if (do_pop) begin
                valid[head] <= 1'b0;
                head        <= next_ptr(head);
            end
            if (do_push) begin
                valid[tail] <= 1'b1;
                tail        <= next_ptr(tail);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
            if (overflow_set) wb_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            ent_rd[tail]   <= EXrd_wb;
            ent_data[tail] <= EXdata_wb;
        end
    end

`ifdef WB_BYPASS_EN
    logic [PW-1:0] idx;

    // Walk from head to tail so the newest matching entry overrides older ones and the registered write.
    always_comb begin
        idx       = '0;
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        if (rf_we && (rf_waddr == byp_rs1) && (byp_rs1 != '0)) begin
            byp_hit1  = 1'b1;
            byp_data1 = rf_wdata;
        end
        if (rf_we && (rf_waddr == byp_rs2) && (byp_rs2 != '0)) begin
            byp_hit2  = 1'b1;
            byp_data2 = rf_wdata;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = PW'((int'(head) + i) % DEPTH);
            if ((CW'(i) < cnt) && valid[idx]) begin
                if ((ent_rd[idx] == byp_rs1) && (byp_rs1 != '0)) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = ent_data[idx];
                end
                if ((ent_rd[idx] == byp_rs2) && (byp_rs2 != '0)) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = ent_data[idx];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH=2): direct/buffered writes, supersede, stall, overflow, async reset.
// Bypass queries are exercised only when WB_BYPASS_EN is defined.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        EXen_wb;
    logic [4:0]  EXrd_wb;
    logic [31:0] EXdata_wb;
    logic        Men_wb;
    logic [4:0]  Mrd_wb;
    logic [31:0] Mdata_wb;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_stall;
    logic        wb_overflow;
    logic [1:0]  wb_cnt;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_rs1;
    logic [4:0]  byp_rs2;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;
`endif

    int compared   = 0;
    int mismatched = 0;

    wb_arbiter #(.DEPTH(2), .RF_IDX_WIDTH(5), .rv32_XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .EXen_wb     (EXen_wb),
        .EXrd_wb     (EXrd_wb),
        .EXdata_wb   (EXdata_wb),
        .Men_wb      (Men_wb),
        .Mrd_wb      (Mrd_wb),
        .Mdata_wb    (Mdata_wb),
`ifdef WB_BYPASS_EN
        .byp_rs1     (byp_rs1),
        .byp_rs2     (byp_rs2),
        .byp_hit1    (byp_hit1),
        .byp_hit2    (byp_hit2),
        .byp_data1   (byp_data1),
        .byp_data2   (byp_data2),
`endif
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .wb_stall    (wb_stall),
        .wb_overflow (wb_overflow),
        .wb_cnt      (wb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's requests, let the next rising edge sample them, then settle just past it.
    task automatic applyStimulus(input logic ex_en, input logic [4:0] ex_rd, input logic [31:0] ex_data,
                                 input logic m_en, input logic [4:0] m_rd, input logic [31:0] m_data);
        EXen_wb   = ex_en;
        EXrd_wb   = ex_rd;
        EXdata_wb = ex_data;
        Men_wb    = m_en;
        Mrd_wb    = m_rd;
        Mdata_wb  = m_data;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input string tag, input logic we, input logic [4:0] addr, input logic [31:0] data);
        checkOutput({tag, ".we"}, {31'd0, rf_we}, {31'd0, we});
        checkOutput({tag, ".waddr"}, {27'd0, rf_waddr}, {27'd0, addr});
        checkOutput({tag, ".wdata"}, rf_wdata, data);
    endtask

    initial begin
        rst_n = 1'b0;
`ifdef WB_BYPASS_EN
        byp_rs1 = '0;
        byp_rs2 = '0;
`endif
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkWrite("reset", 0, 0, 0);
        checkOutput("reset.stall", {31'd0, wb_stall}, 0);
        checkOutput("reset.ovf", {31'd0, wb_overflow}, 0);
        checkOutput("reset.cnt", {30'd0, wb_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lone EX goes straight through.
        applyStimulus(1, 5, 32'h11, 0, 0, 0);
        checkWrite("ex_direct", 1, 5, 32'h11);
        checkOutput("ex_direct.cnt", {30'd0, wb_cnt}, 0);

        // Collision: load first, EX next cycle.
        applyStimulus(1, 4, 32'hBB, 1, 3, 32'hAA);
        checkWrite("collide.load", 1, 3, 32'hAA);
        checkOutput("collide.cnt1", {30'd0, wb_cnt}, 1);
        checkOutput("collide.stall1", {31'd0, wb_stall}, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkWrite("collide.ex", 1, 4, 32'hBB);
        checkOutput("collide.cnt0", {30'd0, wb_cnt}, 0);
        checkOutput("collide.stall0", {31'd0, wb_stall}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkWrite("idle.hold", 0, 4, 32'hBB);

        // x0 requests are ignored; an ignored load lets the EX through directly.
        applyStimulus(1, 0, 32'hDEAD, 0, 0, 0);
        checkWrite("rd0.ex", 0, 4, 32'hBB);
        applyStimulus(1, 6, 32'h66, 1, 0, 32'hBEEF);
        checkWrite("rd0.load", 1, 6, 32'h66);
        checkOutput("rd0.cnt", {30'd0, wb_cnt}, 0);

        // Supersede: buffered rd7 is overtaken by a later load to rd7.
        applyStimulus(1, 7, 32'h1, 1, 1, 32'h10);
        checkWrite("sup.park", 1, 1, 32'h10);
        applyStimulus(0, 0, 0, 1, 7, 32'h2);
        checkWrite("sup.load", 1, 7, 32'h2);
        checkOutput("sup.cnt1", {30'd0, wb_cnt}, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkWrite("sup.stale", 0, 7, 32'h2);
        checkOutput("sup.cnt0", {30'd0, wb_cnt}, 0);

`ifdef WB_BYPASS_EN
        applyStimulus(1, 9, 32'h55, 1, 1, 32'h01);
        applyStimulus(1, 9, 32'h66, 1, 2, 32'h02);
        byp_rs1 = 5'd9;
        byp_rs2 = 5'd0;
        #1;
        checkOutput("byp.hit1", {31'd0, byp_hit1}, 1);
        checkOutput("byp.data1", byp_data1, 32'h66);
        checkOutput("byp.hit2", {31'd0, byp_hit2}, 0);
        byp_rs1 = 5'd2;
        #1;
        checkOutput("byp.rfhit", {31'd0, byp_hit1}, 1);
        checkOutput("byp.rfdata", byp_data1, 32'h02);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("byp.drain", {30'd0, wb_cnt}, 0);
`endif

        // Loads every cycle, EX withheld while stalled.
        applyStimulus(1, 8, 32'h80, 1, 2, 32'h20);
        checkWrite("stall.l1", 1, 2, 32'h20);
        checkOutput("stall.rise", {31'd0, wb_stall}, 1);
        applyStimulus(0, 0, 0, 1, 3, 32'h30);
        checkWrite("stall.l2", 1, 3, 32'h30);
        checkOutput("stall.cnt", {30'd0, wb_cnt}, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkWrite("stall.pop", 1, 8, 32'h80);
        checkOutput("stall.ovf", {31'd0, wb_overflow}, 0);

        // Ignore the stall until the FIFO overflows; rd12 is dropped.
        applyStimulus(1, 10, 32'hA0, 1, 2, 32'h21);
        applyStimulus(1, 11, 32'hB0, 1, 3, 32'h31);
        checkOutput("ovf.full", {30'd0, wb_cnt}, 2);
        checkOutput("ovf.pre", {31'd0, wb_overflow}, 0);
        applyStimulus(1, 12, 32'hC0, 1, 4, 32'h41);
        checkWrite("ovf.load", 1, 4, 32'h41);
        checkOutput("ovf.set", {31'd0, wb_overflow}, 1);
        checkOutput("ovf.cnt", {30'd0, wb_cnt}, 2);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkWrite("ovf.pop1", 1, 10, 32'hA0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkWrite("ovf.pop2", 1, 11, 32'hB0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkWrite("ovf.dropped", 0, 11, 32'hB0);
        checkOutput("ovf.sticky", {31'd0, wb_overflow}, 1);

        // Asynchronous reset in mid-cycle discards the pending entry.
        applyStimulus(1, 13, 32'hD0, 1, 5, 32'h51);
        checkOutput("rst.pending", {30'd0, wb_cnt}, 1);
        EXen_wb = 1'b0;
        Men_wb  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst.cnt", {30'd0, wb_cnt}, 0);
        checkWrite("rst.async", 0, 0, 0);
        checkOutput("rst.ovf", {31'd0, wb_overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkWrite("rst.after", 0, 0, 0);
        checkOutput("rst.after.cnt", {30'd0, wb_cnt}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execute/LSU stage and the single-write-port register file. It accepts the EX result writeback (`EXrd_wb`/`EXdata_wb`/`EXen_wb`) and the LSU load writeback (`Mrd_wb`/`Mdata_wb`/`Men_wb`), which can collide in the same cycle. It gives loads priority and parks colliding EX results in a small in-order FIFO. It raises a stall toward the issue stage before that FIFO can overflow.

## Interface
Parameters:
- `DEPTH`, default 2: EX pending-FIFO entries; legal values 2..4.

Ports:
- `clk`, input, 1: core clock.
- `rst_n`, input, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `EXen_wb`, input, 1: EX writeback request.
- `EXrd_wb`, input, `RF_IDX_WIDTH`: EX destination register.
- `EXdata_wb`, input, `rv32_XLEN`: EX result.
- `Men_wb`, input, 1: load writeback request.
- `Mrd_wb`, input, `RF_IDX_WIDTH`: load destination register.
- `Mdata_wb`, input, `rv32_XLEN`: load data.
- `rf_we`, output, 1: registered register-file write enable.
- `rf_waddr`, output, `RF_IDX_WIDTH`: registered write address.
- `rf_wdata`, output, `rv32_XLEN`: registered write data.
- `wb_stall`, output, 1: issue stage must not issue an EX-writing instruction this cycle.
- `wb_overflow`, output, 1: sticky error flag; set when an EX push is dropped because the FIFO is full.
- `wb_cnt`, output, `$clog2(DEPTH+1)`: current FIFO occupancy.

## Operation
- A request with rd == 0 is ignored entirely: no write and no push.
- FIFO entry fields: {valid, rd, data}. Pushes go to the tail and pops come from the head; pointers wrap modulo `DEPTH`.
- Per-cycle selection of the write candidate, in priority order:
  1. `Men_wb`: write the LSU request. If `EXen_wb` is also high, push the EX request.
  2. FIFO non-empty: pop the head and write it if its valid bit is set. If `EXen_wb` is high, push it in the same cycle (simultaneous push and pop; count unchanged).
  3. `EXen_wb` with an empty FIFO: write EX directly with no push.
  4. Otherwise `rf_we` = 0.
- Supersede rule: on `Men_wb`, every stored entry (not the one pushed this cycle) whose rd == `Mrd_wb` has its valid bit cleared. Stored entries are older than the arriving load, so the load value wins. The EX request pushed in the same cycle is younger and is kept.
- An invalid head pops in one cycle with `rf_we` = 0.
- Push while full (count == `DEPTH` and no pop): the EX data is dropped and `wb_overflow` is set until reset.
- `wb_stall` = (count >= `DEPTH`-1). It is decoded from registers only, which guarantees one free slot for the cycle in which the stall takes effect.

## Timing
- Latency: inputs sampled at edge N appear on `rf_we`/`rf_waddr`/`rf_wdata` after edge N, so they are valid throughout cycle N+1.
- Fixed one-cycle latency for the LSU and direct-EX paths. A buffered EX result is delayed one additional cycle per preceding load or FIFO entry.
- Reset values:
  - `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0.
  - `wb_stall` = 0, `wb_overflow` = 0, `wb_cnt` = 0.
  - All valid bits cleared and both pointers at 0.
- Reset asserted mid-operation discards all pending entries immediately (asynchronous). No write is issued for them.
- `wb_stall` and `wb_cnt` change only at clock edges.
- `rf_waddr`/`rf_wdata` hold their last value when `rf_we` = 0.

## Configuration
- `WB_BYPASS_EN` defined: adds two query ports for the decode operand read:
  - `byp_rs1` and `byp_rs2`: inputs, `RF_IDX_WIDTH`.
  - `byp_hit1` and `byp_hit2`: outputs, 1.
  - `byp_data1` and `byp_data2`: outputs, `rv32_XLEN`.
  - Lookup is combinational. It returns the newest valid FIFO entry matching rs; otherwise it returns the registered `rf_w*` output if `rf_we` is high and the address matches. rs == 0 never hits.
- `WB_BYPASS_EN` undefined: these ports are absent. The issue stage must then stall on any pending rd via `wb_cnt` != 0.

## Test plan
- Reset, then EX rd=5 data=0x11 alone → cycle+1: `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x11. `wb_cnt` stays 0.
- Same cycle: load rd=3 data=0xAA and EX rd=4 data=0xBB → writes (3,0xAA) then (4,0xBB) on consecutive cycles. `wb_cnt` goes 1 then 0.
- Supersede: FIFO holds EX rd=7 data=0x1; load rd=7 data=0x2 arrives → rd 7 is written once with 0x2. The stale entry pops with `rf_we`=0.
- Back-to-back loads plus EX every cycle with `DEPTH`=2 → `wb_stall` rises when `wb_cnt`=1. Once the stall is honoured, no EX push is lost and `wb_overflow` stays 0.
- Force an EX push while full (stall ignored by the bench) → that entry is dropped and `wb_overflow`=1 until reset. Mid-stream `rst_n` low → `wb_cnt`=0 and no further writes.
- `WB_BYPASS_EN`: FIFO holds (9,0x55) and (9,0x66, newer); query rs1=9 → `byp_hit1`=1, `byp_data1`=0x66. Query rs2=0 → `byp_hit2`=0.
